// File: rtl/fp_mul_result_stage.sv
// Registered special-case resolution stage behind the combinational FP64 multiplier (2-deep valid/ready).
// Define FPMUL_FLAGS_EN to build the NV/OF/UF flag and sticky-flag registers; otherwise both outputs read 0.
module fp_mul_result_stage #(
    parameter logic [63:0] QNAN = 64'h7FF8_0000_0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] op_a,
    input  logic [63:0] op_b,
    input  logic [63:0] raw_prod,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic [2:0]  flags,
    output logic [2:0]  sticky_flags,
    input  logic        flags_clr
);

    // Operand class as {snan, qnan, inf, zero}; subnormals count as zero.
    function automatic logic [3:0] classify(input logic [63:0] x);
        logic exp_max_s;
        logic man_nz_s;
        exp_max_s = (x[62:52] == 11'h7FF);
        man_nz_s  = (x[51:0] != 52'd0);
        classify  = {exp_max_s && !x[51] && man_nz_s,
                     exp_max_s && x[51],
                     exp_max_s && !man_nz_s,
                     x[62:52] == 11'h000};
    endfunction

    logic        s1_v_q, s1_v_d;
    logic        s2_v_q, s2_v_d;
    logic        s1_sign_q;
    logic [11:0] s1_esum_q;
    logic [3:0]  s1_cls_a_q, s1_cls_b_q;
    logic [62:0] s1_prod_q;
    logic [63:0] result_q, result_d;
    logic [2:0]  flags_d;

    logic        s2_adv_s, s1_load_s, s2_load_s;
    logic [10:0] adj_s;
    logic signed [12:0] etrue_s;
    logic        nan_any_s, snan_any_s, inf_a_s, inf_b_s, zero_a_s, zero_b_s;
    logic        unused_prod_sign_s;

    assign unused_prod_sign_s = raw_prod[63];

    assign s2_adv_s  = !s2_v_q || out_ready;
    assign in_ready  = !s1_v_q || s2_adv_s;
    assign s1_load_s = in_valid && in_ready;
    assign s2_load_s = s1_v_q && s2_adv_s;
    assign out_valid = s2_v_q;
    assign result    = result_q;

    // Next-state of both pipeline valid bits.
    always_comb begin
        if (s1_load_s) begin
            s1_v_d = 1'b1;
        end else if (s2_load_s) begin
            s1_v_d = 1'b0;
        end else begin
            s1_v_d = s1_v_q;
        end
        if (s2_load_s) begin
            s2_v_d = 1'b1;
        end else if (out_ready) begin
            s2_v_d = 1'b0;
        end else begin
            s2_v_d = s2_v_q;
        end
    end

    // Valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
        end
    end

    // S1 capture of sign, exponent sum, operand classes and the raw product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sign_q  <= 1'b0;
            s1_esum_q  <= 12'd0;
            s1_cls_a_q <= 4'd0;
            s1_cls_b_q <= 4'd0;
            s1_prod_q  <= 63'd0;
        end else if (s1_load_s) begin
            s1_sign_q  <= op_a[63] ^ op_b[63];
            s1_esum_q  <= {1'b0, op_a[62:52]} + {1'b0, op_b[62:52]};
            s1_cls_a_q <= classify(op_a);
            s1_cls_b_q <= classify(op_b);
            s1_prod_q  <= raw_prod[62:0];
        end else begin
            s1_sign_q  <= s1_sign_q;
            s1_esum_q  <= s1_esum_q;
            s1_cls_a_q <= s1_cls_a_q;
            s1_cls_b_q <= s1_cls_b_q;
            s1_prod_q  <= s1_prod_q;
        end
    end

    // The multiplier's exponent field already carries the normalise/round increment; recover it mod 2048.
    assign adj_s      = s1_prod_q[62:52] - (s1_esum_q[10:0] - 11'd1023);
    assign etrue_s    = $signed({1'b0, s1_esum_q}) - 13'sd1023 + $signed({2'b00, adj_s});
    assign nan_any_s  = s1_cls_a_q[3] | s1_cls_a_q[2] | s1_cls_b_q[3] | s1_cls_b_q[2];
    assign snan_any_s = s1_cls_a_q[3] | s1_cls_b_q[3];
    assign inf_a_s    = s1_cls_a_q[1];
    assign inf_b_s    = s1_cls_b_q[1];
    assign zero_a_s   = s1_cls_a_q[0];
    assign zero_b_s   = s1_cls_b_q[0];

    // Special-case priority chain producing the S2 result and {NV, OF, UF}.
    always_comb begin
        result_d = 64'd0;
        flags_d  = 3'b000;
        if (nan_any_s) begin
            result_d = QNAN;
            flags_d  = {snan_any_s, 2'b00};
        end else if ((inf_a_s && zero_b_s) || (zero_a_s && inf_b_s)) begin
            result_d = QNAN;
            flags_d  = 3'b100;
        end else if (inf_a_s || inf_b_s) begin
            result_d = {s1_sign_q, 11'h7FF, 52'd0};
        end else if (zero_a_s || zero_b_s) begin
            result_d = {s1_sign_q, 63'd0};
        end else if (etrue_s >= 13'sd2047) begin
            result_d = {s1_sign_q, 11'h7FF, 52'd0};
            flags_d  = 3'b010;
        end else if (etrue_s <= 13'sd0) begin
            result_d = {s1_sign_q, 63'd0};
            flags_d  = 3'b001;
        end else begin
            result_d = {s1_sign_q, etrue_s[10:0], s1_prod_q[51:0]};
        end
    end

    // S2 result register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 64'd0;
        end else if (s2_load_s) begin
            result_q <= result_d;
        end else begin
            result_q <= result_q;
        end
    end

`ifdef FPMUL_FLAGS_EN
    logic [2:0] flags_q;
    logic [2:0] sticky_q, sticky_d;

    // A flag loaded on the same cycle as a clear survives the clear.
    always_comb begin
        sticky_d = (flags_clr ? 3'b000 : sticky_q) | (s2_load_s ? flags_d : 3'b000);
    end

    // Per-result flags and accumulated sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q  <= 3'b000;
            sticky_q <= 3'b000;
        end else begin
            flags_q  <= s2_load_s ? flags_d : flags_q;
            sticky_q <= sticky_d;
        end
    end

    assign flags        = flags_q;
    assign sticky_flags = sticky_q;
`else
    logic unused_flags_s;
    assign unused_flags_s = ^{flags_d, flags_clr};
    assign flags          = 3'b000;
    assign sticky_flags   = 3'b000;
`endif

endmodule

// File: tb/tb_fp_mul_result_stage.sv
// Randomised self-checking bench for fp_mul_result_stage with a behavioural scoreboard.
module tb_fp_mul_result_stage;

    localparam logic [63:0] QNAN_C = 64'h7FF8_0000_0000_0000;
`ifdef FPMUL_FLAGS_EN
    localparam logic [2:0] FMASK = 3'b111;
`else
    localparam logic [2:0] FMASK = 3'b000;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] op_a, op_b, raw_prod;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic [2:0]  flags;
    logic [2:0]  sticky_flags;
    logic        flags_clr;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ready_mode = 0;
    int          cyc = 0;
    logic [3:0]  ready_pat = 4'b1001;
    logic [66:0] exp_next;
    logic [66:0] sb_q[$];
    logic        held_v = 1'b0;
    logic [63:0] held_r;
    logic [2:0]  or_acc = 3'b000;

    fp_mul_result_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .raw_prod(raw_prod),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flags(flags), .sticky_flags(sticky_flags), .flags_clr(flags_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: IEEE special cases from field values, true exponent as plain integer arithmetic.
    function automatic logic [66:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                              input int adj, input logic [51:0] m);
        int ea, eb, et;
        bit sg, za, zb, ia, ib, na, nb, sa, sb;
        logic [63:0] r;
        logic [2:0]  f;
        ea = int'(a[62:52]);
        eb = int'(b[62:52]);
        sg = a[63] ^ b[63];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 2047) && (a[51:0] == 52'd0);
        ib = (eb == 2047) && (b[51:0] == 52'd0);
        na = (ea == 2047) && (a[51:0] != 52'd0);
        nb = (eb == 2047) && (b[51:0] != 52'd0);
        sa = na && !a[51];
        sb = nb && !b[51];
        et = ea + eb - 1023 + adj;
        f  = 3'b000;
        if (na || nb) begin
            r = QNAN_C;
            f = {sa || sb, 2'b00};
        end else if ((ia && zb) || (za && ib)) begin
            r = QNAN_C;
            f = 3'b100;
        end else if (ia || ib) r = {sg, 11'h7FF, 52'd0};
        else if (za || zb) r = {sg, 63'd0};
        else if (et >= 2047) begin
            r = {sg, 11'h7FF, 52'd0};
            f = 3'b010;
        end else if (et <= 0) begin
            r = {sg, 63'd0};
            f = 3'b001;
        end else r = {sg, 11'(et), m};
        return {f & FMASK, r};
    endfunction

    // What the multiplier would output: exponent field wraps mod 2048, adj is the rounding bump.
    function automatic logic [63:0] make_raw(input logic [63:0] a, input logic [63:0] b,
                                             input int adj, input logic [51:0] m);
        int e;
        e = int'(a[62:52]) + int'(b[62:52]) - 1023 + adj;
        e = ((e % 2048) + 2048) % 2048;
        return {1'($urandom_range(0, 1)), 11'(e), m};
    endfunction

    function automatic logic [63:0] rand_op();
        logic [63:0] t;
        logic        s;
        int          k;
        t = {$urandom, $urandom};
        s = 1'($urandom_range(0, 1));
        k = $urandom_range(0, 11);
        case (k)
            0: rand_op = {s, 11'h000, t[51:0]};
            1: rand_op = {s, 11'h7FF, 52'd0};
            2: rand_op = {s, 11'h7FF, 1'b1, t[50:0]};
            3: rand_op = {s, 11'h7FF, 1'b0, t[50:1], 1'b1};
            4: rand_op = {s, 11'($urandom_range(1, 40)), t[51:0]};
            5: rand_op = {s, 11'($urandom_range(2000, 2046)), t[51:0]};
            6, 7: rand_op = {s, 11'($urandom_range(900, 1150)), t[51:0]};
            default: rand_op = {s, 11'($urandom_range(1, 2046)), t[51:0]};
        endcase
    endfunction

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] raw,
                        input logic [66:0] exp);
        logic acc;
        op_a     = a;
        op_b     = b;
        raw_prod = raw;
        exp_next = exp;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
        end
        check_eq("accept", acc, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [63:0] a, input logic [63:0] b, input int adj);
        logic [63:0] t;
        t = {$urandom, $urandom};
        send(a, b, make_raw(a, b, adj, t[51:0]), ref_model(a, b, adj, t[51:0]));
    endtask

    task automatic drain();
        ready_mode = 0;
        for (int i = 0; i < 500 && sb_q.size() != 0; i++) @(negedge clk);
        check_eq("drain", sb_q.size(), 0);
    endtask

    task automatic pulse_clr();
        flags_clr = 1'b1;
        @(posedge clk);
        #1;
        flags_clr = 1'b0;
    endtask

    // Consumer-ready generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ready_pat[cyc % 4];
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            cyc++;
        end
    end

    // Scoreboard: ordering, stall stability and in_ready back-pressure.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            held_v = 1'b0;
        end else begin
            check_eq("in_ready", in_ready, !(sb_q.size() == 2 && !out_ready));
            if (held_v) begin
                check_eq("stall_valid", out_valid, 1);
                check_eq("stall_result", result, held_r);
            end
            if (out_valid) begin
                if (sb_q.size() == 0) check_eq("spurious_out", out_valid, 0);
                else begin
                    check_eq("result", result, sb_q[0][63:0]);
                    check_eq("flags", flags, sb_q[0][66:64]);
                    if (out_ready) begin
                        or_acc = or_acc | sb_q[0][66:64];
                        void'(sb_q.pop_front());
                    end
                end
            end
            held_v = out_valid && !out_ready;
            held_r = result;
            if (in_valid && in_ready) sb_q.push_back(exp_next);
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flags_clr = 1'b0; out_ready = 1'b1;
        op_a = 64'd0; op_b = 64'd0; raw_prod = 64'd0; exp_next = 67'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_result", result, 0);
        check_eq("rst_flags", flags, 0);
        check_eq("rst_sticky", sticky_flags, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1.5 x 2.0: two-cycle latency
        send(64'h3FF8_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000,
             {3'b000, 64'h4008_0000_0000_0000});
        @(negedge clk);
        check_eq("lat1_valid", out_valid, 0);
        @(negedge clk);
        check_eq("lat2_valid", out_valid, 1);
        check_eq("lat2_result", result, 64'h4008_0000_0000_0000);

        send(64'h7FF0_0000_0000_0000, 64'h0, 64'h0, {3'b100 & FMASK, QNAN_C});
        send(64'h7FF4_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h7FF4_0000_0000_0000,
             {3'b100 & FMASK, QNAN_C});
        send(64'h7FF8_0000_0000_0001, 64'h3FF0_0000_0000_0000, 64'h7FF8_0000_0000_0001,
             {3'b000, QNAN_C});
        send(64'h7FE0_0000_0000_0000, 64'h7FE0_0000_0000_0000, 64'h3FD0_0000_0000_0000,
             {3'b010 & FMASK, 64'h7FF0_0000_0000_0000});
        send(64'h0010_0000_0000_0000, 64'h0010_0000_0000_0000, 64'h4030_0000_0000_0000,
             {3'b001 & FMASK, 64'h0});
        send(64'hC000_0000_0000_0000, 64'h0008_0000_0000_0000, 64'h0,
             {3'b000, 64'h8000_0000_0000_0000});
        send(64'h7FF0_0000_0000_0000, 64'hC000_0000_0000_0000, 64'h0,
             {3'b000, 64'hFFF0_0000_0000_0000});

        // Exponent boundaries: 2046 normal, 2047 overflow, 1 normal, 0 underflow.
        send_model({1'b0, 11'd1023, 52'd0}, {1'b0, 11'd2046, 52'h12345}, 0);
        send_model({1'b0, 11'd1023, 52'd0}, {1'b1, 11'd2046, 52'h12345}, 1);
        send_model({1'b0, 11'd1023, 52'd7}, {1'b0, 11'd2045, 52'h1}, 2);
        send_model({1'b0, 11'd1, 52'd0}, {1'b0, 11'd1023, 52'h5}, 0);
        send_model({1'b1, 11'd1, 52'd0}, {1'b0, 11'd1022, 52'h5}, 0);
        send_model({1'b0, 11'd1, 52'd0}, {1'b0, 11'd1022, 52'h5}, 1);
        drain();

        // Reset with both stages full
        ready_mode = 3;
        @(posedge clk);
        #2;
        send(64'h7FE0_0000_0000_0000, 64'h7FE0_0000_0000_0000, 64'h3FD0_0000_0000_0000,
             {3'b010 & FMASK, 64'h7FF0_0000_0000_0000});
        send(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000,
             {3'b000, 64'h3FF0_0000_0000_0000});
        @(negedge clk);
        check_eq("full_in_ready", in_ready, 0);
        check_eq("full_out_valid", out_valid, 1);
        check_eq("full_sticky", sticky_flags, 3'b010 & FMASK);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_in_ready", in_ready, 1);
        check_eq("arst_sticky", sticky_flags, 0);
        check_eq("arst_result", result, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ready_mode = 0;

        // Sticky flags: same-cycle clear and load
        @(posedge clk);
        #2;
        send(64'h7FF0_0000_0000_0000, 64'h0, 64'h0, {3'b100 & FMASK, QNAN_C});
        drain();
        @(negedge clk);
        check_eq("sticky_nv", sticky_flags, 3'b100 & FMASK);
        send(64'h7FE0_0000_0000_0000, 64'h7FE0_0000_0000_0000, 64'h3FD0_0000_0000_0000,
             {3'b010 & FMASK, 64'h7FF0_0000_0000_0000});
        pulse_clr();
        @(negedge clk);
        check_eq("sticky_clr_load", sticky_flags, 3'b010 & FMASK);
        pulse_clr();
        @(negedge clk);
        check_eq("sticky_clr", sticky_flags, 0);
        drain();

        // Streams: 8 back-to-back with ready 1,0,0,1 then random traffic
        or_acc = 3'b000;
        ready_mode = 1;
        for (int i = 0; i < 8; i++) send_model(rand_op(), rand_op(), $urandom_range(0, 2));
        ready_mode = 2;
        for (int i = 0; i < 250; i++) begin
            send_model(rand_op(), rand_op(), $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        @(negedge clk);
        check_eq("sticky_stream", sticky_flags, or_acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
